// File: rtl/jk_edge_meter.sv
// jk_edge_meter: synchronises JK flop q, emits edge pulses, counts toggles per window and measures high phases
module jk_edge_meter #(
  parameter int CNT_W   = 16,
  parameter int WIN_LEN = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_in,
  input  logic             en,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic             cnt_valid,
  output logic [CNT_W-1:0] high_len,
  output logic             high_len_valid,
  output logic             overflow
);
  localparam int WW = $clog2(WIN_LEN);
  localparam logic [CNT_W-1:0] MAX = '1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q, s3_q, rise_q, fall_q, rise_d, fall_d;
  logic [WW-1:0] win_q, win_d;
  logic [CNT_W-1:0] edge_q, edge_d, hcnt_q, hcnt_d, tog_q, tog_d, hl_q, hl_d, edge_sum;
  logic armed_q, armed_d, cv_q, cv_d, hlv_q, hlv_d, ovf_q, ovf_d;
  logic edge_w, edge_sat, hsat, win_end;
  always_comb begin
    rise_d   = s2_q & ~s3_q;
    fall_d   = ~s2_q & s3_q;
    edge_w   = rise_q | fall_q;
    edge_sat = edge_w && edge_q == MAX;
    edge_sum = edge_sat ? MAX : edge_q + CNT_W'(edge_w);
    hsat     = armed_q && !rise_q && !fall_q && hcnt_q == MAX;
    win_end  = win_q == WW'(WIN_LEN - 1);
    state_d  = state_q;
    win_d    = win_q;
    edge_d   = edge_q;
    hcnt_d   = hcnt_q;
    armed_d  = armed_q;
    tog_d    = tog_q;
    hl_d     = hl_q;
    cv_d     = 1'b0;
    hlv_d    = 1'b0;
    ovf_d    = ovf_q;
    if (state_q == IDLE || !en) begin
      state_d = (state_q == IDLE && en) ? RUN : IDLE;
      win_d   = '0;
      edge_d  = '0;
      hcnt_d  = '0;
      armed_d = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      win_d  = win_end ? '0 : win_q + WW'(1);
      edge_d = win_end ? '0 : edge_sum;
      tog_d  = win_end ? edge_sum : tog_q;
      cv_d   = win_end;
      ovf_d  = ovf_q | edge_sat | hsat;
      if (rise_q) begin
        hcnt_d  = CNT_W'(1);
        armed_d = 1'b1;
      end else if (fall_q && armed_q) begin
        hl_d    = hcnt_q;
        hlv_d   = 1'b1;
        armed_d = 1'b0;
      end else if (armed_q && !hsat) begin
        hcnt_d = hcnt_q + CNT_W'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      {s1_q, s2_q, s3_q, rise_q, fall_q} <= '0;
      win_q   <= '0;
      edge_q  <= '0;
      hcnt_q  <= '0;
      armed_q <= 1'b0;
      tog_q   <= '0;
      hl_q    <= '0;
      cv_q    <= 1'b0;
      hlv_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      {s1_q, s2_q, s3_q} <= {q_in, s1_q, s2_q};
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      win_q   <= win_d;
      edge_q  <= edge_d;
      hcnt_q  <= hcnt_d;
      armed_q <= armed_d;
      tog_q   <= tog_d;
      hl_q    <= hl_d;
      cv_q    <= cv_d;
      hlv_q   <= hlv_d;
      ovf_q   <= ovf_d;
    end
  end
  assign rise_pulse     = rise_q;
  assign fall_pulse     = fall_q;
  assign toggle_cnt     = tog_q;
  assign cnt_valid      = cv_q;
  assign high_len       = hl_q;
  assign high_len_valid = hlv_q;
  assign overflow       = ovf_q;
endmodule

// File: tb/tb_jk_edge_meter.sv
// tb_jk_edge_meter: directed checks of edge pulses, window counts, high length and saturation
module tb_jk_edge_meter;
  logic clk = 1'b0, rst = 1'b1;
  logic qa = 1'b1, ena = 1'b1, qb = 1'b0, enb = 1'b0;
  logic rise_a, fall_a, cv_a, hlv_a, ovf_a, rise_b, fall_b, cv_b, hlv_b, ovf_b;
  logic [15:0] tog_a, hl_a;
  logic [3:0] tog_b, hl_b;
  int n_cmp = 0, n_bad = 0;
  int cyc, nr, nf, ncv, nhlv, tr, tf, tcv, thl, nb;
  always #5 clk = ~clk;
  jk_edge_meter #(.CNT_W(16), .WIN_LEN(20)) u_a (
    .clk(clk), .rst(rst), .q_in(qa), .en(ena), .rise_pulse(rise_a), .fall_pulse(fall_a),
    .toggle_cnt(tog_a), .cnt_valid(cv_a), .high_len(hl_a), .high_len_valid(hlv_a), .overflow(ovf_a));
  jk_edge_meter #(.CNT_W(4), .WIN_LEN(64)) u_b (
    .clk(clk), .rst(rst), .q_in(qb), .en(enb), .rise_pulse(rise_b), .fall_pulse(fall_b),
    .toggle_cnt(tog_b), .cnt_valid(cv_b), .high_len(hl_b), .high_len_valid(hlv_b), .overflow(ovf_b));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic clr();
    {cyc, nr, nf, ncv, nhlv, tr, tf, tcv, thl} = '0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rise_a) begin nr++; tr = cyc; end
    if (fall_a) begin nf++; tf = cyc; end
    if (cv_a) begin ncv++; if (ncv == 1) tcv = cyc; end
    if (hlv_a) begin nhlv++; if (nhlv == 1) thl = cyc; end
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  initial begin
    ticks(3);
    chk("rst_rise", rise_a, 0);
    chk("rst_fall", fall_a, 0);
    chk("rst_tog", tog_a, 0);
    chk("rst_cv", cv_a, 0);
    chk("rst_hl", hl_a, 0);
    chk("rst_hlv", hlv_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_tog_b", tog_b, 0);
    rst = 1'b0;
    clr();
    ticks(4);
    chk("rst_rise_cnt", nr, 1);
    chk("rst_rise_lat", tr, 3);
    ena = 1'b0; qa = 1'b0;
    ticks(8);
    clr();
    qa = 1'b1;
    ticks(10);
    qa = 1'b0;
    ticks(10);
    chk("lat_rise_cnt", nr, 1);
    chk("lat_fall_cnt", nf, 1);
    chk("lat_rise_at", tr, 3);
    chk("lat_gap", tf - tr, 10);
    chk("lat_no_cv", ncv, 0);
    chk("lat_no_hlv", nhlv, 0);
    clr();
    for (int i = 0; i < 116; i++) begin
      if (i % 2 == 0) qa = ~qa;
      if (i == 6) ena = 1'b1;
      tick();
      if (cv_a) begin
        chk("win_tog", tog_a, 10);
        chk("win_phase", (cyc - 27) % 20, 0);
      end
    end
    chk("win_first", tcv, 27);
    chk("win_count", ncv, 5);
    qa = 1'b0;
    ticks(6);
    chk("win_hl2", hl_a, 2);
    clr();
    qa = 1'b1;
    ticks(7);
    qa = 1'b0;
    ticks(10);
    chk("hl7_val", hl_a, 7);
    chk("hl7_cnt", nhlv, 1);
    chk("hl7_at", thl, 11);
    clr();
    qa = 1'b1;
    tick();
    qa = 1'b0;
    ticks(10);
    chk("hl1_val", hl_a, 1);
    chk("hl1_cnt", nhlv, 1);
    chk("hl1_at", thl, 5);
    ena = 1'b0; qa = 1'b1;
    ticks(6);
    ena = 1'b1;
    clr();
    ticks(3);
    qa = 1'b0;
    ticks(18);
    chk("arm_no_hlv", nhlv, 0);
    chk("arm_cv_cnt", ncv, 1);
    chk("arm_cv_at", tcv, 21);
    chk("arm_tog", tog_a, 1);
    clr();
    qa = 1'b1;
    ticks(4);
    qa = 1'b0;
    ticks(4);
    ena = 1'b0;
    ticks(30);
    chk("abort_no_cv", ncv, 0);
    chk("abort_tog_hold", tog_a, 1);
    ena = 1'b1;
    clr();
    ticks(25);
    chk("reen_cv_cnt", ncv, 1);
    chk("reen_cv_at", tcv, 21);
    chk("reen_tog", tog_a, 0);
    nb = 0;
    for (int i = 0; i < 80; i++) begin
      qb = ~qb;
      if (i == 4) enb = 1'b1;
      tick();
      if (cv_b) begin
        nb++;
        chk("sat_tog", tog_b, 15);
      end
      if (i == 40) chk("sat_ovf_mid", ovf_b, 1);
    end
    chk("sat_cv_cnt", nb, 1);
    chk("sat_ovf_sticky", ovf_b, 1);
    chk("sat_hl1", hl_b, 1);
    enb = 1'b0;
    ticks(2);
    chk("idle_ovf_clr", ovf_b, 0);
    chk("idle_tog_hold", tog_b, 15);
    enb = 1'b1;
    ticks(2);
    chk("reen_ovf", ovf_b, 0);
    for (int i = 0; i < 30; i++) begin
      qb = ~qb;
      tick();
    end
    chk("pre_rst_ovf", ovf_b, 1);
    rst = 1'b1;
    tick();
    chk("rst_mid_ovf", ovf_b, 0);
    chk("rst_mid_tog", tog_b, 0);
    chk("rst_mid_hl", hl_b, 0);
    rst = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
